// File: rtl/btn_debounce_evt.sv
// btn_debounce_evt: push-button conditioning between the pads and the GPIO input.
// Each raw button is synchronised into aclk with two flops, debounced by a
// four-state FSM with a saturating stability counter, and turned into a clean
// level, one-cycle rise/fall pulses, sticky event flags with a software clear,
// and a registered level interrupt.
// Optional build macro BTN_AUTOREPEAT_EN: while a button stays held, extra rise
// pulses are produced REPEAT_DELAY cycles after acceptance and then every
// REPEAT_PERIOD cycles. Without the macro no hold-counter logic exists.
module btn_debounce_evt #(
  parameter int NUM_BTNS        = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [NUM_BTNS-1:0] btns_raw,
  input  logic [NUM_BTNS-1:0] evt_clr,
  output logic [NUM_BTNS-1:0] btns_db,
  output logic [NUM_BTNS-1:0] btns_rise,
  output logic [NUM_BTNS-1:0] btns_fall,
  output logic [NUM_BTNS-1:0] evt_pending,
  output logic                irq
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } db_state_e;

  localparam logic [CNT_WIDTH-1:0] DB_LIMIT = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W  = $clog2(REP_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_DELAY  = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_PERIOD = HOLD_W'(REPEAT_PERIOD);
`endif

  logic [NUM_BTNS-1:0] sync1_q, sync1_d;
  logic [NUM_BTNS-1:0] sync2_q, sync2_d;
  logic [NUM_BTNS-1:0] evt_q, evt_d;
  logic                irq_q, irq_d;

  // Two-flop synchroniser input path; sync2_q is the settled level the FSMs see.
  always_comb begin
    sync1_d = btns_raw;
    sync2_d = sync1_q;
  end

  // Synchroniser registers, cleared by reset so a held button is re-qualified.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    db_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 db_q, db_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 accept_rise;
    logic                 s;

    assign s = sync2_q[i];

    // Debounce FSM: a change is accepted only after the synced level has held
    // for the full count; any reversion during the wait drops back silently.
    always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      accept_rise = 1'b0;
      fall_d      = 1'b0;
      case (state_q)
        IDLE_LO: begin
          if (s) begin
            state_d = WAIT_HI;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state_d = IDLE_LO;
            cnt_d   = '0;
          end else if (cnt_q >= DB_LIMIT) begin
            state_d     = IDLE_HI;
            cnt_d       = '0;
            accept_rise = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!s) begin
            state_d = WAIT_LO;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (s) begin
            state_d = IDLE_HI;
            cnt_d   = '0;
          end else if (cnt_q >= DB_LIMIT) begin
            state_d = IDLE_LO;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end
      endcase
      db_d = (state_d == IDLE_HI) || (state_d == WAIT_LO);
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rep_q, rep_d;
    logic              rep_pulse;
    logic [HOLD_W-1:0] hold_inc;
    logic [HOLD_W-1:0] hold_target;

    // Hold counter: runs only while the channel stays in IDLE_HI; first target
    // is the initial delay, every later target is the repeat period.
    always_comb begin
      hold_d      = '0;
      rep_d       = 1'b0;
      rep_pulse   = 1'b0;
      hold_inc    = hold_q + HOLD_W'(1);
      hold_target = rep_q ? HOLD_PERIOD : HOLD_DELAY;
      if ((state_q == IDLE_HI) && (state_d == IDLE_HI)) begin
        rep_d = rep_q;
        if (hold_inc == hold_target) begin
          rep_pulse = 1'b1;
          hold_d    = '0;
          rep_d     = 1'b1;
        end else begin
          hold_d = hold_inc;
        end
      end
    end

    // Hold counter registers.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        hold_q <= '0;
        rep_q  <= 1'b0;
      end else begin
        hold_q <= hold_d;
        rep_q  <= rep_d;
      end
    end

    assign rise_d = accept_rise | rep_pulse;
`else
    assign rise_d = accept_rise;
`endif

    // Channel state, counter, level and pulse registers.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        state_q <= IDLE_LO;
        cnt_q   <= '0;
        db_q    <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign btns_db[i]   = db_q;
    assign btns_rise[i] = rise_q;
    assign btns_fall[i] = fall_q;
  end

  // Sticky event flags: a pulse sets, a clear strobe clears, set wins a tie;
  // the interrupt follows the OR of the flags one cycle later.
  always_comb begin
    evt_d = (evt_q & ~evt_clr) | btns_rise | btns_fall;
    irq_d = |evt_q;
  end

  // Event flag and interrupt registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      evt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      evt_q <= evt_d;
      irq_q <= irq_d;
    end
  end

  assign evt_pending = evt_q;
  assign irq         = irq_q;

endmodule
